col_lift_engine: RTL

Parametrised CDF 5/3 column lifting engine for the wavelet transformer. It is the successor of the fixed-width column processor. Each pass consumes one row pair across `LENGTH` column positions and produces one low-pass (`s`) and one high-pass (`d`) coefficient per column. Inter-pass state lives in internal per-column banks, so the upstream row buffer supplies only fresh rows. Boundary symmetric extension is applied internally, and both faces use valid/ready flow control.

---
 rtl/col_lift_engine_pkg.sv | 26 ++
 rtl/col_lift_engine_col_bank.sv | 28 ++
 rtl/col_lift_engine.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/col_lift_engine_pkg.sv
// Shared definitions for the CDF 5/3 lifting engines: default geometry,
// the column engine state type and the two lifting step helpers.
package essentials;

    localparam int DEFAULT_LENGTH = 512;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } lift_state_t;

    // Predict step: odd - floor((e0 + e1) / 2).
    // Operands are carried as int so the helper serves any sample width
    // that fits in 30 bits; callers size-cast the result to their own width.
    function automatic int cdf53_d(input int odd, input int e0, input int e1);
        return odd - ((e0 + e1) >>> 1);
    endfunction

    // Update step: e0 + floor((dp + d + 2) / 4), arithmetic shift.
    // The intermediate sum is formed in int so it cannot wrap before the shift.
    function automatic int cdf53_s(input int e0, input int dp, input int d);
        return e0 + ((dp + d + 2) >>> 2);
    endfunction

endpackage

// File: rtl/col_lift_engine_col_bank.sv
// Per-column state memory: one write port and one combinational read port.
// A read and a write to the same address in the same cycle see the old word,
// because the write only lands on the clock edge.
module col_bank #(
    parameter int W     = 8,
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/col_lift_engine.sv
// CDF 5/3 column lifting engine. One pass walks LENGTH columns of a row pair,
// producing one low-pass (s) and one high-pass (d) coefficient per column.
// Previous-pass even rows and high-pass values are kept in two column banks.
//
// Handshakes: a beat transfers on a rising edge where valid && ready are both
// high. The producer holds valid and data stable until the transfer; ready
// may change freely. Outputs stay stable while out_valid && !out_ready.
module col_lift_engine
    import essentials::*;
#(
    parameter int DATA_W = 8,
    parameter int LENGTH = DEFAULT_LENGTH,
    parameter int CNT_W  = $clog2(LENGTH)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic                first_pass,
    input  logic                last_pass,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   row_0,
    input  logic [DATA_W-1:0]   row_1,
    input  logic [DATA_W-1:0]   row_2,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W+1:0]   s,
    output logic [DATA_W:0]     d,
    output logic [CNT_W-1:0]    col_idx,
    output logic                busy,
    output logic                done
);

    lift_state_t state, state_nxt;

    logic              first_q, last_q;
    logic [CNT_W-1:0]  cnt;
    logic              last_beat;
    logic              in_fire;

    // Stage 1 registers
    logic                     s1_valid;
    logic [DATA_W-1:0]        s1_e0;
    logic signed [DATA_W:0]   s1_d;
    logic signed [DATA_W:0]   s1_dp;
    logic [CNT_W-1:0]         s1_col;

    // Pipeline flow control
    logic out_load_ok;
    logic s1_load_ok;

    // Bank ports
    logic [DATA_W-1:0] even_rd;
    logic [DATA_W:0]   d_rd;

    // Stage 1 / stage 2 combinational results
    logic [DATA_W-1:0]      e0, e1;
    logic signed [DATA_W:0] d_new, dp;
    logic [DATA_W+1:0]      s_new;

    assign out_load_ok = !out_valid || out_ready;
    assign s1_load_ok  = !s1_valid || out_load_ok;
    assign in_fire     = in_valid && in_ready;
    assign last_beat   = (cnt == CNT_W'(LENGTH - 1));

    // Next-state, in_ready, busy and done decode.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        done      = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                in_ready = s1_load_ok;
                if (in_valid && s1_load_ok && last_beat) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!s1_valid && !out_valid) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register, latched pass flags and column counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            cnt     <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && start) begin
                first_q <= first_pass;
                last_q  <= last_pass;
                cnt     <= '0;
            end else if (in_fire) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Predict step: select even neighbours, with symmetric extension at the
    // image top (row_0 is fresh) and bottom (row_2 mirrors e0).
    always_comb begin
        e0    = first_q ? row_0 : even_rd;
        e1    = last_q ? e0 : row_2;
        d_new = (DATA_W + 1)'(cdf53_d(int'(row_1), int'(e0), int'(e1)));
        dp    = first_q ? d_new : $signed(d_rd);
    end

    // Update step on the stage 1 contents.
    always_comb begin
        s_new = (DATA_W + 2)'(cdf53_s(int'(s1_e0), int'(s1_dp), int'(s1_d)));
    end

    col_bank #(.W(DATA_W), .DEPTH(LENGTH), .AW(CNT_W)) u_even_bank (
        .clk   (clk),
        .we    (in_fire),
        .waddr (cnt),
        .wdata (e1),
        .raddr (cnt),
        .rdata (even_rd)
    );

    col_bank #(.W(DATA_W + 1), .DEPTH(LENGTH), .AW(CNT_W)) u_d_bank (
        .clk   (clk),
        .we    (in_fire),
        .waddr (cnt),
        .wdata (d_new),
        .raddr (cnt),
        .rdata (d_rd)
    );

    // Stage 1: capture the accepted beat with its bank-derived operands.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_e0    <= '0;
            s1_d     <= '0;
            s1_dp    <= '0;
            s1_col   <= '0;
        end else if (s1_load_ok) begin
            s1_valid <= in_fire;
            if (in_fire) begin
                s1_e0  <= e0;
                s1_d   <= d_new;
                s1_dp  <= dp;
                s1_col <= cnt;
            end
        end
    end

    // Stage 2: registered outputs, held while the consumer stalls.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            s         <= '0;
            d         <= '0;
            col_idx   <= '0;
        end else if (out_load_ok) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                s       <= s_new;
                d       <= s1_d;
                col_idx <= s1_col;
            end
        end
    end

endmodule
